// File: rtl/divider_if.sv
// divider_if: request/result bundle between the execute stage and the divider
interface divider_if;
    logic [31:0] i_in_a;
    logic [31:0] i_in_b;
    logic [2:0]  i_funct3;
    logic        i_div_en;
    logic [31:0] o_result;
    logic        o_busy;

    modport slave (
        input  i_in_a, i_in_b, i_funct3, i_div_en,
        output o_result, o_busy
    );

    modport master (
        output i_in_a, i_in_b, i_funct3, i_div_en,
        input  o_result, o_busy
    );
endinterface

// File: rtl/divider.sv
// divider: iterative RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle, single-cycle fast path for /0 and overflow
module divider (
    input  logic      i_clk_n,
    input  logic      i_rst_n,
    divider_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] q_q, q_d;
    logic [31:0] b_q, b_d;
    logic [32:0] rem_q, rem_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic        sel_rem_q, sel_rem_d;
    logic [31:0] result_q, result_d;

    logic        is_signed, sa, sb, div_zero, ovf, ge;
    logic [31:0] abs_a, abs_b, q_step, q_fix, r_fix;
    logic [32:0] rem_sh, rem_step;
    logic        unused_ok;

    // funct3[2] only marks the M-extension group; the decoder has already qualified it
    assign unused_ok = bus.i_funct3[2];

    assign is_signed = ~bus.i_funct3[0];
    assign sa        = is_signed & bus.i_in_a[31];
    assign sb        = is_signed & bus.i_in_b[31];
    assign abs_a     = sa ? -bus.i_in_a : bus.i_in_a;
    assign abs_b     = sb ? -bus.i_in_b : bus.i_in_b;
    assign div_zero  = bus.i_in_b == 32'd0;
    assign ovf       = is_signed & (bus.i_in_a == 32'h8000_0000) & (bus.i_in_b == 32'hFFFF_FFFF);

    assign rem_sh    = {rem_q[31:0], q_q[31]};
    assign ge        = rem_sh >= {1'b0, b_q};
    assign rem_step  = ge ? rem_sh - {1'b0, b_q} : rem_sh;
    assign q_step    = {q_q[30:0], ge};
    assign q_fix     = neg_q_q ? -q_step : q_step;
    assign r_fix     = neg_r_q ? -rem_step[31:0] : rem_step[31:0];

    // Next-state and datapath: load in IDLE, shift-subtract in RUN, sign fix on the final step
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        b_d       = b_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        sel_rem_d = sel_rem_q;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (bus.i_div_en) begin
                    if (div_zero) begin
                        result_d = bus.i_funct3[1] ? bus.i_in_a : 32'hFFFF_FFFF;
                        state_d  = DONE;
                    end else if (ovf) begin
                        result_d = bus.i_funct3[1] ? 32'd0 : 32'h8000_0000;
                        state_d  = DONE;
                    end else begin
                        q_d       = abs_a;
                        b_d       = abs_b;
                        rem_d     = 33'd0;
                        cnt_d     = 6'd32;
                        neg_q_d   = sa ^ sb;
                        neg_r_d   = sa;
                        sel_rem_d = bus.i_funct3[1];
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (!bus.i_div_en) begin
                    state_d = IDLE;
                end else begin
                    q_d   = q_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        result_d = sel_rem_q ? r_fix : q_fix;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge i_clk_n or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            q_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            sel_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            sel_rem_q <= sel_rem_d;
            result_q  <= result_d;
        end
    end

    assign bus.o_result = result_q;
    assign bus.o_busy   = i_rst_n & bus.i_div_en & (state_q != DONE);
endmodule
